// File: rtl/io_out_fifo.sv
// Output-port buffer: captures processor writes {port, data} and drains them over valid/ready.
// Optional almost-full interrupt enabled by defining IO_OUT_FIFO_AF_ITR_EN.
module io_out_fifo #(
    parameter int unsigned NUBITS = 16,
    parameter int unsigned NUIOOU = 2,
    parameter int unsigned FDEPTH = 8,
    parameter int unsigned AFTHR  = 6,
    localparam int unsigned AW    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
    localparam int unsigned CW    = $clog2(FDEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUBITS-1:0] io_out,
    input  logic [AW-1:0]     addr_out,
    input  logic              out_en,
    output logic [NUBITS-1:0] m_data,
    output logic [AW-1:0]     m_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              itr_af
);

    localparam int unsigned PW = $clog2(FDEPTH);
    localparam int unsigned EW = AW + NUBITS;
    localparam bit CFG_OK = (FDEPTH >= 2) && ((FDEPTH & (FDEPTH - 1)) == 0) &&
                            (AFTHR >= 1) && (AFTHR <= FDEPTH);

    if (!CFG_OK) begin : g_cfg_err
        $error("io_out_fifo: FDEPTH must be a power of two >= 2 and 1 <= AFTHR <= FDEPTH");
    end

    logic [EW-1:0]     mem_q [FDEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic [NUBITS-1:0] data_q, data_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              addr_ok;
    logic              push;
    logic              pop;

    // Handshake decode and next-state for pointers, occupancy, flags and head register
    always_comb begin
        addr_ok  = (32'(addr_out) < NUIOOU);
        pop      = valid_q && m_ready;
        push     = out_en && addr_ok && (!full_q || pop);
        wr_ptr_d = push ? PW'(wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? PW'(rd_ptr_q + PW'(1)) : rd_ptr_q;
        count_d  = CW'(count_q + CW'(push) - CW'(pop));
        full_d   = (count_d == CW'(FDEPTH));
        valid_d  = (count_d != '0);
        ovf_d    = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (out_en && addr_ok && full_q && !pop) ovf_d = 1'b1;
        data_d   = data_q;
        addr_d   = addr_q;
        // Head register holds its last value while the FIFO is empty
        if (valid_d) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                data_d = io_out;
                addr_d = addr_out;
            end else begin
                {addr_d, data_d} = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {addr_out, io_out};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
        end
    end

`ifdef IO_OUT_FIFO_AF_ITR_EN
    logic itr_af_q, itr_af_d;

    always_comb begin
        itr_af_d = (32'(count_d) >= AFTHR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) itr_af_q <= 1'b0;
        else      itr_af_q <= itr_af_d;
    end

    assign itr_af = itr_af_q;
`else
    assign itr_af = 1'b0;
`endif

    assign m_data  = data_q;
    assign m_addr  = addr_q;
    assign m_valid = valid_q;
    assign count   = count_q;
    assign full    = full_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed bench for io_out_fifo; itr_af expectations follow IO_OUT_FIFO_AF_ITR_EN.
module tb_io_out_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] io_out;
    logic [0:0]  addr_out;
    logic        out_en;
    logic [15:0] m_data;
    logic [0:0]  m_addr;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  count;
    logic        full;
    logic        ovf;
    logic        ovf_clr;
    logic        itr_af;

    int tests = 0;
    int fails = 0;

    io_out_fifo dut (
        .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
        .m_data(m_data), .m_addr(m_addr), .m_valid(m_valid), .m_ready(m_ready),
        .count(count), .full(full), .ovf(ovf), .ovf_clr(ovf_clr), .itr_af(itr_af)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_af(input int c);
`ifdef IO_OUT_FIFO_AF_ITR_EN
        return 32'(c >= 6);
`else
        return 32'(c >= 1000);
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; io_out = '0; addr_out = '0; out_en = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        step(); step();
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(m_valid), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_af", 32'(itr_af), 0);
        chk("rst_data", 32'(m_data), 0);
        rst = 1'b1;
        step();

        // Three words on port 1, then drain in order
        addr_out = 1'b1; out_en = 1'b1;
        io_out = 16'h0011; step();
        chk("t1_lat_valid", 32'(m_valid), 1);
        io_out = 16'h0022; step();
        io_out = 16'h0033; step();
        out_en = 1'b0;
        chk("t1_count", 32'(count), 3);
        chk("t1_valid", 32'(m_valid), 1);
        chk("t1_addr", 32'(m_addr), 1);
        chk("t1_data", 32'(m_data), 32'h0011);
        step();
        chk("t1_hold", 32'(m_data), 32'h0011);
        m_ready = 1'b1;
        chk("t1_pop0", 32'(m_data), 32'h0011); step();
        chk("t1_pop1", 32'(m_data), 32'h0022); step();
        chk("t1_pop2", 32'(m_data), 32'h0033); step();
        m_ready = 1'b0;
        chk("t1_empty_count", 32'(count), 0);
        chk("t1_empty_valid", 32'(m_valid), 0);

        // Fill to 8, overflow with 0xDEAD, drain, clear
        out_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            io_out = 16'(16'h0100 + i); addr_out = 1'(i); step();
            chk("t2_fill_af", 32'(itr_af), exp_af(i + 1));
        end
        chk("t2_full", 32'(full), 1);
        chk("t2_ovf_pre", 32'(ovf), 0);
        io_out = 16'hDEAD; step();
        out_en = 1'b0;
        chk("t2_ovf", 32'(ovf), 1);
        chk("t2_count", 32'(count), 8);
        chk("t2_full2", 32'(full), 1);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t2_drain_data", 32'(m_data), 32'h0100 + 32'(i));
            chk("t2_drain_addr", 32'(m_addr), 32'(i % 2));
            step();
        end
        m_ready = 1'b0;
        chk("t2_drained", 32'(count), 0);
        chk("t2_full_off", 32'(full), 0);
        chk("t2_ovf_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
        chk("t2_ovf_clr", 32'(ovf), 0);

        // Push into a full FIFO on the same edge as a pop
        out_en = 1'b1; addr_out = 1'b0;
        for (int i = 0; i < 8; i++) begin
            io_out = 16'(16'h0200 + i); step();
        end
        m_ready = 1'b1; io_out = 16'hBEEF; step();
        out_en = 1'b0;
        chk("t3_ovf", 32'(ovf), 0);
        chk("t3_count", 32'(count), 8);
        for (int i = 1; i < 8; i++) begin
            chk("t3_pop", 32'(m_data), 32'h0200 + 32'(i)); step();
        end
        chk("t3_beef", 32'(m_data), 32'hBEEF); step();
        m_ready = 1'b0;
        chk("t3_empty", 32'(count), 0);

        // Steady push/pop at count 1 across pointer wrap
        out_en = 1'b1; io_out = 16'h0055; step();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            io_out = 16'(i);
            chk("t4_head", 32'(m_data), (i == 0) ? 32'h0055 : 32'(i - 1));
            step();
            chk("t4_count", 32'(count), 1);
        end
        out_en = 1'b0;
        chk("t4_last", 32'(m_data), 32'd19);
        step(); m_ready = 1'b0;
        chk("t4_empty", 32'(count), 0);

        // Asynchronous reset mid-burst
        out_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            io_out = 16'(16'h0300 + i); step();
        end
        out_en = 1'b0;
        chk("t5_count", 32'(count), 5);
        #3 rst = 1'b0;
        #1;
        chk("t5_async_count", 32'(count), 0);
        chk("t5_async_valid", 32'(m_valid), 0);
        chk("t5_async_data", 32'(m_data), 0);
        step(); rst = 1'b1;
        out_en = 1'b1; io_out = 16'h00AA; addr_out = 1'b0; step(); out_en = 1'b0;
        chk("t5_data", 32'(m_data), 32'h00AA);
        chk("t5_count1", 32'(count), 1);
        m_ready = 1'b1; step(); m_ready = 1'b0;

        // Almost-full threshold crossing
        out_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            io_out = 16'(i); step();
            chk("t6_af_fill", 32'(itr_af), exp_af(i + 1));
        end
        out_en = 1'b0; m_ready = 1'b1; step(); m_ready = 1'b0;
        chk("t6_af_pop", 32'(itr_af), exp_af(5));
        chk("t6_count", 32'(count), 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_out_fifo.md
Name: io_out_fifo

Overview:
- Output-port buffer that sits directly downstream of the processor's output bus.
- Captures every processor write (io_out data, addr_out port number, out_en strobe) into a FIFO of {port, data} entries.
- Drains entries to the external peripheral side through a valid/ready handshake.
- The processor cannot stall on output, so the block absorbs bursts and flags overflow instead of back-pressuring.

Parameters:
- NUBITS, 16, data word width; matches the processor word.
- NUIOOU, 2, number of processor output ports; port field width is $clog2(NUIOOU), minimum 1.
- FDEPTH, 8, FIFO depth in entries; must be a power of two, >= 2.
- AFTHR, 6, almost-full threshold in entries, 1 <= AFTHR <= FDEPTH; used only by the optional feature.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- io_out  in  NUBITS  processor output data word.
- addr_out  in  $clog2(NUIOOU)  processor output port number.
- out_en  in  1  processor output write strobe, one cycle per word.
- m_data  out  NUBITS  head-entry data.
- m_addr  out  $clog2(NUIOOU)  head-entry port number.
- m_valid  out  1  head entry present.
- m_ready  in  1  consumer accepts the head entry.
- count  out  $clog2(FDEPTH)+1  current occupancy, 0..FDEPTH.
- full  out  1  count == FDEPTH.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf.
- itr_af  out  1  almost-full interrupt request toward the processor itr input.

Behaviour:
- Reset (rst low, asynchronous):
  - write pointer, read pointer and count go to 0.
  - m_valid, full, ovf and itr_af go to 0.
  - m_data and m_addr go to 0.
  - Storage contents are don't-care.
  - Reset asserted mid-burst discards all entries; the first push after rst returns high lands in slot 0.
- Push:
  - Occurs at a clock edge when out_en = 1 and (count < FDEPTH, or a pop occurs in the same cycle).
  - Writes {addr_out, io_out} at the write pointer; the pointer increments modulo FDEPTH and wraps naturally.
- Pop:
  - Occurs at a clock edge when m_valid = 1 and m_ready = 1; the read pointer increments modulo FDEPTH.
  - m_ready while m_valid = 0 has no effect.
- Occupancy:
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged, including at count = 0 (push only) and count = FDEPTH (both occur; no overflow).
- Read timing (registered first-word-fall-through):
  - m_valid = (count != 0); m_data/m_addr always show the entry at the read pointer.
  - A push into an empty FIFO gives m_valid = 1 one cycle after the out_en edge.
  - m_data/m_addr are stable while m_valid = 1 and m_ready = 0.
- Overflow:
  - out_en = 1 with count = FDEPTH and no pop drops the word; no pointer or count change.
  - ovf is set at that edge and stays set until ovf_clr = 1 at an edge.
  - If set and clear coincide, set wins.
- Out-of-range port: with NUIOOU not a power of two, addr_out >= NUIOOU is silently discarded. It is not pushed and does not set ovf.
- Latency: out_en edge to m_valid is 1 cycle when empty. Throughput is one push and one pop per cycle.
- full is registered and consistent with count every cycle.

Optional Feature:
- Macro: IO_OUT_FIFO_AF_ITR_EN.
- Defined:
  - itr_af is a registered level, 1 when count >= AFTHR, else 0; it updates on the same edge as count.
  - It is intended for the processor itr input so software can pause output before overflow.
  - It deasserts on the first edge where count drops below AFTHR.
- Undefined:
  - itr_af is constant 0 and the AFTHR comparator is not synthesized.
  - AFTHR is ignored.

Test Plan:
- Reset, then push 3 words (port 1: 0x0011, 0x0022, 0x0033) with m_ready = 0 -> count = 3, m_valid = 1, m_addr = 1, m_data = 0x0011. Then m_ready = 1 for 3 cycles -> 0x0011, 0x0022, 0x0033 in order; count = 0, m_valid = 0.
- Push 8 words with m_ready = 0, then a 9th (0xDEAD) -> full = 1, ovf = 1, count = 8. Drain all -> 0xDEAD never appears. Pulse ovf_clr -> ovf = 0.
- With count = 8 and m_ready = 1, push 0xBEEF on the same edge -> ovf stays 0, count stays 8, and 0xBEEF emerges 8 pops later.
- Push and pop every cycle for 20 cycles (data 0..19) starting from count = 1 -> count stays 1 and the output sequence is preserved across pointer wrap.
- With count = 5, assert rst low between clock edges -> all outputs are 0 immediately. After release, push 0x00AA -> m_data = 0x00AA and count = 1.
- With IO_OUT_FIFO_AF_ITR_EN defined and AFTHR = 6: push 6 -> itr_af = 1 on the 6th edge; pop 1 -> itr_af = 0. With the macro undefined -> itr_af stays 0 throughout.
